// File: rtl/bht_update_scheduler_if.sv
// Handshake and table-port bundle for the BHT update scheduler.
// master is the pipeline/table side, slave is the scheduler.
interface bht_update_scheduler_if #(
    parameter int INDEX_W = 10,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               PredValid;
    logic [INDEX_W-1:0] PredPC;
    logic               PredReady;
    logic               PredRespValid;
    logic [1:0]         PredCounter;

    logic               CommitValid;
    logic [INDEX_W-1:0] CommitPC;
    logic               CommitTaken;
    logic [1:0]         CommitCounter;
    logic               CommitReady;

    logic               FlushReq;
    logic               InitBusy;
    logic [CNT_W-1:0]   QueueCount;

    logic [INDEX_W-1:0] TblAddr;
    logic               TblWrEn;
    logic [1:0]         TblWrData;
    logic [1:0]         TblRdData;

    modport master (
        output PredValid, PredPC,
        output CommitValid, CommitPC, CommitTaken, CommitCounter,
        output FlushReq, TblRdData,
        input  PredReady, PredRespValid, PredCounter,
        input  CommitReady, InitBusy, QueueCount,
        input  TblAddr, TblWrEn, TblWrData
    );

    modport slave (
        input  PredValid, PredPC,
        input  CommitValid, CommitPC, CommitTaken, CommitCounter,
        input  FlushReq, TblRdData,
        output PredReady, PredRespValid, PredCounter,
        output CommitReady, InitBusy, QueueCount,
        output TblAddr, TblWrEn, TblWrData
    );
endinterface

// File: rtl/bht_update_scheduler.sv
// Single-port BHT owner: arbitrates prediction reads against queued
// commit updates and sweeps the table to INIT_VALUE after reset/flush.
module bht_update_scheduler #(
    parameter int         INDEX_W    = 10,
    parameter int         DEPTH      = 4,
    parameter logic [1:0] INIT_VALUE = 2'b01
) (
    input logic clk,
    input logic rstn,
    bht_update_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {START, INIT, RUN} state_t;

    typedef struct packed {
        logic [INDEX_W-1:0] pc;
        logic               taken;
        logic [1:0]         counter;
    } entry_t;

    state_t             state;
    entry_t             fifo [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   headPtr;
    logic [PTR_W-1:0]   tailPtr;
    logic [CNT_W-1:0]   count;
    logic [INDEX_W-1:0] initAddr;
    logic [INDEX_W-1:0] lastAddr;
    logic               respValid;
    logic [1:0]         heldCounter;

    logic               full;
    logic               empty;
    logic               running;
    logic               rdAccept;
    logic               push;
    logic               pop;
    logic [INDEX_W-1:0] tblAddr;
    logic               tblWrEn;
    logic [1:0]         tblWrData;
    logic [1:0]         predCounter;

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? c : c + 2'd1;
        else   return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign running  = (state == RUN);
    assign head     = fifo[headPtr];
    assign rdAccept = bus.PredValid & running & ~full;
    // Flush wins over the queue: nothing queued may reach the table.
    assign push     = bus.CommitValid & running & ~full & ~bus.FlushReq;
    assign pop      = running & ~rdAccept & ~empty & ~bus.FlushReq;

    always_comb begin
        tblAddr   = lastAddr;
        tblWrEn   = 1'b0;
        tblWrData = 2'b00;
        case (state)
            INIT: begin
                tblAddr   = initAddr;
                tblWrEn   = 1'b1;
                tblWrData = INIT_VALUE;
            end
            RUN: begin
                unique case (1'b1)
                    rdAccept: tblAddr = bus.PredPC;
                    pop: begin
                        tblAddr   = head.pc;
                        tblWrEn   = 1'b1;
                        tblWrData = sat(head.counter, head.taken);
                    end
                    default: ;
                endcase
            end
            default: tblAddr = '0;
        endcase
    end

    assign predCounter = respValid ? bus.TblRdData : heldCounter;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= START;
            initAddr    <= '0;
            lastAddr    <= '0;
            respValid   <= 1'b0;
            heldCounter <= 2'b00;
        end else begin
            lastAddr    <= tblAddr;
            respValid   <= rdAccept;
            heldCounter <= predCounter;
            case (state)
                START: begin
                    state    <= INIT;
                    initAddr <= '0;
                end
                INIT: begin
                    if (bus.FlushReq) begin
                        initAddr <= '0;
                    end else if (initAddr == '1) begin
                        state    <= RUN;
                        initAddr <= '0;
                    end else begin
                        initAddr <= initAddr + 1'b1;
                    end
                end
                RUN: begin
                    if (bus.FlushReq) begin
                        state    <= INIT;
                        initAddr <= '0;
                    end
                end
                default: state <= START;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else if (bus.FlushReq) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (push) tailPtr <= tailPtr + 1'b1;
            if (pop)  headPtr <= headPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[tailPtr] <= '{
                pc:      bus.CommitPC,
                taken:   bus.CommitTaken,
                counter: bus.CommitCounter
            };
        end
    end

    assign bus.PredReady     = running & ~full;
    assign bus.CommitReady   = running & ~full;
    assign bus.PredRespValid = respValid;
    assign bus.PredCounter   = predCounter;
    assign bus.InitBusy      = ~running;
    assign bus.QueueCount    = count;
    assign bus.TblAddr       = tblAddr;
    assign bus.TblWrEn       = tblWrEn;
    assign bus.TblWrData     = tblWrData;
endmodule
